// File: rtl/strip_chart_pkg.sv
// rtl/strip_chart_pkg.sv - shared types, palette and helpers for the strip-chart plotter
//
// Purpose: FSM state encoding, channel palette lookup and a constant clog2
// used to size counters and addresses in the plotter and its pixel RAM.
// Ports: none (package).

package strip_chart_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_PLOT  = 3'd3,
    ST_ADV   = 3'd4
  } state_t;

  // Never returns less than 1 so a single-entry range still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Word 0 is a blank pixel; word k+1 is channel k.
  function automatic logic [7:0] palette_byte(input logic [2:0] word);
    logic [7:0] b;
    case (word)
      3'd1:    b = 8'h17;
      3'd2:    b = 8'hE0;
      3'd3:    b = 8'h1C;
      3'd4:    b = 8'h03;
      3'd5:    b = 8'hFC;
      3'd6:    b = 8'h1F;
      3'd7:    b = 8'hE3;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/strip_chart_ram.sv
// rtl/strip_chart_ram.sv - simple dual-port pixel RAM with registered read
//
// Purpose: one write port and one independent registered read port.
// Ports:
//   i_clk    clock
//   i_reset  sync active-high, clears the read register only
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, valid the cycle after i_raddr

module strip_chart_ram
  import strip_chart_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/strip_chart_plotter.sv
// rtl/strip_chart_plotter.sv - multi-channel strip-chart plotter into a pixel buffer
//
// Purpose: on each tick, clears the current write column, plots one pixel per
// enabled channel, then advances the column. A display read port returns a
// palette byte per (x,y) one cycle after the coordinates are presented.
// Ports:
//   i_clock    system clock
//   i_reset    sync active-high; aborts any operation and restarts INIT
//   i_tick     1-cycle sample strobe
//   i_sample   channel k at [k*VAL_W +: VAL_W], latched on an accepted tick
//   i_ch_en    per-channel plot enable, latched on an accepted tick
//   i_rd_x     display column (screen)
//   i_rd_y     display row, 0 = top of screen
//   o_dout     palette byte for (i_rd_x,i_rd_y), one cycle latency
//   o_busy     high outside IDLE
//   o_overrun  sticky until reset: a tick arrived while busy
//   o_wr_col   physical column the next sample goes to

module strip_chart_plotter
  import strip_chart_pkg::*;
#(
  parameter int COLS   = 300,
  parameter int ROWS   = 100,
  parameter int NCH    = 2,
  parameter int VAL_W  = 16,
  parameter int SCROLL = 1,
  parameter int XW     = clog2(COLS),
  parameter int YW     = clog2(ROWS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [NCH*VAL_W-1:0] i_sample,
  input  logic [NCH-1:0]       i_ch_en,
  input  logic [XW-1:0]        i_rd_x,
  input  logic [YW-1:0]        i_rd_y,
  output logic [7:0]           o_dout,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic [XW-1:0]        o_wr_col
);

  localparam int CW = clog2(NCH + 1);
  localparam int AW = clog2(COLS * ROWS);
  localparam int KW = clog2(NCH);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(COLS * ROWS - 1);
  localparam logic [YW-1:0]    TOP_ROW   = YW'(ROWS - 1);
  localparam logic [XW-1:0]    LAST_COL  = XW'(COLS - 1);
  localparam logic [KW-1:0]    LAST_CH   = KW'(NCH - 1);
  localparam logic [VAL_W-1:0] TOP_VAL   = VAL_W'(ROWS - 1);
  localparam logic [XW:0]      COLS_X    = (XW + 1)'(COLS);

  state_t r_state, w_next;

  logic [AW-1:0]        r_init_addr;
  logic [YW-1:0]        r_row;
  logic [KW-1:0]        r_ch;
  logic [XW-1:0]        r_wr_col;
  logic [NCH*VAL_W-1:0] r_samp;
  logic [NCH-1:0]       r_en;
  logic                 r_overrun;

  logic                 w_we;
  logic [AW-1:0]        w_waddr;
  logic [CW-1:0]        w_wdata;
  logic [VAL_W-1:0]     w_chan_val;
  logic [YW-1:0]        w_plot_row;
  logic [XW:0]          w_sum;
  logic [XW-1:0]        w_pcol;
  logic [YW-1:0]        w_prow;
  logic [AW-1:0]        w_raddr;
  logic [CW-1:0]        w_rword;

  function automatic logic [AW-1:0] pix_addr(input logic [YW-1:0] row,
                                             input logic [XW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:  if (r_init_addr == LAST_ADDR) w_next = ST_IDLE;
      ST_IDLE:  if (i_tick) w_next = ST_CLEAR;
      ST_CLEAR: if (r_row == TOP_ROW) w_next = ST_PLOT;
      ST_PLOT:  if (r_ch == LAST_CH) w_next = ST_ADV;
      ST_ADV:   w_next = ST_IDLE;
      default:  w_next = ST_INIT;
    endcase
  end

  // Counters, sample latch and sticky overrun
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_init_addr <= '0;
      r_row       <= '0;
      r_ch        <= '0;
      r_wr_col    <= '0;
      r_samp      <= '0;
      r_en        <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_INIT: r_init_addr <= r_init_addr + 1'b1;
        ST_IDLE: begin
          r_row <= '0;
          r_ch  <= '0;
          if (i_tick) begin
            r_samp <= i_sample;
            r_en   <= i_ch_en;
          end
        end
        ST_CLEAR: r_row <= r_row + 1'b1;
        ST_PLOT:  r_ch  <= r_ch + 1'b1;
        ST_ADV:   r_wr_col <= (r_wr_col == LAST_COL) ? '0 : r_wr_col + 1'b1;
        default: ;
      endcase
    end
  end

  // Clamp the active channel's sample to the top row
  assign w_chan_val = r_samp[r_ch*VAL_W +: VAL_W];
  assign w_plot_row = (w_chan_val > TOP_VAL) ? TOP_ROW : w_chan_val[YW-1:0];

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_init_addr;
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = pix_addr(r_row, r_wr_col);
      end
      ST_PLOT: begin
        w_we    = r_en[r_ch];
        w_waddr = pix_addr(w_plot_row, r_wr_col);
        w_wdata = CW'(r_ch) + 1'b1;
      end
      default: ;
    endcase
  end

  // Screen-to-physical mapping; the sum stays below 2*COLS so one subtract wraps it
  assign w_sum  = {1'b0, i_rd_x} + {1'b0, r_wr_col};
  assign w_pcol = ((SCROLL != 0) && (w_sum >= COLS_X)) ? XW'(w_sum - COLS_X)
                : (SCROLL != 0) ? w_sum[XW-1:0] : i_rd_x;
  assign w_prow = TOP_ROW - i_rd_y;
  assign w_raddr = pix_addr(w_prow, w_pcol);

  strip_chart_ram #(
    .DEPTH (COLS * ROWS),
    .WIDTH (CW),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clock),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rword)
  );

  assign o_dout    = palette_byte(3'(w_rword));
  assign o_busy    = (r_state != ST_IDLE);
  assign o_overrun = r_overrun;
  assign o_wr_col  = r_wr_col;

endmodule

// File: tb/tb_strip_chart_plotter.sv
// tb/tb_strip_chart_plotter.sv - self-checking bench for strip_chart_plotter

module tb_strip_chart_plotter;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int NCH  = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, tick0, tick1;
  logic [31:0] sample;
  logic [1:0]  ch_en;
  logic [2:0]  rd_x;
  logic [1:0]  rd_y;
  logic [7:0]  dout0, dout1;
  logic        busy0, busy1, ovr0, ovr1;
  logic [2:0]  wc0, wc1;

  int errors = 0;
  int checks = 0;

  strip_chart_plotter #(.COLS(COLS), .ROWS(ROWS), .NCH(NCH), .VAL_W(16), .SCROLL(0)) u0 (
    .i_clock(clk), .i_reset(rst0), .i_tick(tick0), .i_sample(sample), .i_ch_en(ch_en),
    .i_rd_x(rd_x), .i_rd_y(rd_y), .o_dout(dout0), .o_busy(busy0), .o_overrun(ovr0),
    .o_wr_col(wc0)
  );

  strip_chart_plotter #(.COLS(COLS), .ROWS(ROWS), .NCH(NCH), .VAL_W(16), .SCROLL(1)) u1 (
    .i_clock(clk), .i_reset(rst1), .i_tick(tick1), .i_sample(sample), .i_ch_en(ch_en),
    .i_rd_x(rd_x), .i_rd_y(rd_y), .o_dout(dout1), .o_busy(busy1), .o_overrun(ovr1),
    .o_wr_col(wc1)
  );

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [1:0]  en;
    logic [2:0]  col;
    logic [31:0] exp;   // screen y at [8*y +: 8]
    logic [2:0]  nxt;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? busy0 : busy1) && (n < 200)) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input int sel);
    @(negedge clk);
    if (sel == 0) tick0 = 1'b1; else tick1 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    tick1 = 1'b0;
  endtask

  task automatic read_px(input int x, input int y, output logic [7:0] d0, output logic [7:0] d1);
    @(negedge clk);
    rd_x = 3'(x);
    rd_y = 2'(y);
    @(negedge clk);
    d0 = dout0;
    d1 = dout1;
  endtask

  initial begin
    int          n;
    logic [7:0]  d0, d1;
    logic [31:0] e;

    vt[0] = '{16'd2,     16'd0, 2'b11, 3'd0, 32'hE000_1700, 3'd1};
    vt[1] = '{16'd9,     16'd9, 2'b11, 3'd1, 32'h0000_00E0, 3'd2};
    vt[2] = '{16'd9,     16'd9, 2'b01, 3'd2, 32'h0000_0017, 3'd3};
    vt[3] = '{16'd1,     16'd3, 2'b10, 3'd3, 32'h0000_00E0, 3'd4};
    vt[4] = '{16'd0,     16'd0, 2'b00, 3'd4, 32'h0000_0000, 3'd5};
    vt[5] = '{16'd3,     16'd1, 2'b11, 3'd5, 32'h00E0_0017, 3'd6};
    vt[6] = '{16'd0,     16'd0, 2'b01, 3'd6, 32'h1700_0000, 3'd7};
    vt[7] = '{16'hFFFF,  16'd2, 2'b11, 3'd7, 32'h0000_E017, 3'd0};
    vt[8] = '{16'd1,     16'd0, 2'b01, 3'd0, 32'h0017_0000, 3'd1};

    rst0 = 1'b1; rst1 = 1'b1; tick0 = 1'b0; tick1 = 1'b0;
    sample = '0; ch_en = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy0), 32'd1);
    check("reset_dout", 32'(dout0), 32'h0);
    check("reset_overrun", 32'(ovr0), 32'd0);
    check("reset_wr_col", 32'(wc0), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    wait_idle(0, n);
    check("init_busy_cycles", n, 32);
    check("init_overrun", 32'(ovr0), 32'd0);
    check("init_wr_col", 32'(wc0), 32'd0);

    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++) begin
        read_px(x, y, d0, d1);
        check("init_blank", 32'(d0), 32'h0);
      end

    // Table: one tick per record, then read back the column it drew
    for (int i = 0; i < 9; i++) begin
      sample = {vt[i].s1, vt[i].s0};
      ch_en  = vt[i].en;
      pulse(0);
      wait_idle(0, n);
      check("tick_busy_cycles", n, 7);
      check("tick_wr_col", 32'(wc0), 32'(vt[i].nxt));
      e = vt[i].exp;
      for (int y = 0; y < ROWS; y++) begin
        read_px(int'(vt[i].col), y, d0, d1);
        check("vec_pixel", 32'(d0), 32'(e[8*y +: 8]));
      end
      if (i == 0) begin
        for (int x = 1; x < COLS; x++)
          for (int y = 0; y < ROWS; y++) begin
            read_px(x, y, d0, d1);
            check("first_tick_others_blank", 32'(d0), 32'h0);
          end
      end
    end
    check("no_overrun_yet", 32'(ovr0), 32'd0);

    // Tick in the very first IDLE cycle after a plot must be accepted
    sample = {16'd0, 16'd2};
    ch_en  = 2'b01;
    pulse(0);
    wait_idle(0, n);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    wait_idle(0, n);
    check("b2b_busy_cycles", n, 7);
    check("b2b_wr_col", 32'(wc0), 32'd3);
    check("b2b_overrun", 32'(ovr0), 32'd0);
    read_px(1, 1, d0, d1);
    check("b2b_col1", 32'(d0), 32'h17);
    read_px(2, 1, d0, d1);
    check("b2b_col2", 32'(d0), 32'h17);
    read_px(2, 0, d0, d1);
    check("b2b_col2_old_gone", 32'(d0), 32'h0);

    // Tick two cycles into a plot is dropped and sets the sticky flag
    ch_en = 2'b00;
    pulse(0);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    wait_idle(0, n);
    check("ovr_set", 32'(ovr0), 32'd1);
    check("ovr_wr_col_once", 32'(wc0), 32'd4);
    repeat (10) @(negedge clk);
    check("ovr_sticky", 32'(ovr0), 32'd1);
    pulse(0);
    wait_idle(0, n);
    check("ovr_after_tick", 32'(ovr0), 32'd1);
    check("ovr_next_wr_col", 32'(wc0), 32'd5);

    // Scroll-mode instance: newest column sits at the right edge
    ch_en = 2'b01;
    for (int k = 0; k < 3; k++) begin
      sample = {16'd0, 16'(k)};
      pulse(1);
      wait_idle(1, n);
      check("scroll_busy_cycles", n, 7);
    end
    check("scroll_wr_col", 32'(wc1), 32'd3);
    read_px(5, 3, d0, d1);
    check("scroll_x5_y3", 32'(d1), 32'h17);
    read_px(6, 2, d0, d1);
    check("scroll_x6_y2", 32'(d1), 32'h17);
    read_px(7, 1, d0, d1);
    check("scroll_x7_y1", 32'(d1), 32'h17);
    read_px(6, 3, d0, d1);
    check("scroll_x6_y3_blank", 32'(d1), 32'h0);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < ROWS; y++) begin
        read_px(x, y, d0, d1);
        check("scroll_left_blank", 32'(d1), 32'h0);
      end

    // Reset in the middle of CLEAR restarts INIT and wipes everything
    pulse(1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    wait_idle(1, n);
    check("midreset_init_cycles", n, 32);
    check("midreset_wr_col", 32'(wc1), 32'd0);
    check("midreset_overrun", 32'(ovr1), 32'd0);
    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++) begin
        read_px(x, y, d0, d1);
        check("midreset_blank", 32'(d1), 32'h0);
      end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
